// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared opcodes, state encoding and ALU mux selects for the
//            command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_MAC = 2'd3;

   // These encodings must match the ALU's own src mux decode
   localparam logic [2:0] SRC1_ACCUM = 3'b000;
   localparam logic [2:0] SRC0_PCOMP = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_MAC_ADD = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Returns {mult4, mult2}; mult4 wins when both scale bits are set
   function automatic logic [1:0] scale_bits(input logic [1:0] scale);
      return {scale[1], scale[0] & ~scale[1]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mult_timer.sv
// ============================================================================
// Module   : alu_mult_timer
// Brief    : Loadable down-counter; last is high on the final multiply cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mult_timer #(
   parameter int MULT_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic last
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = 4'(MULT_CYC - 1);
      end else if (en && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_seq.sv
// ============================================================================
// Module   : alu_cmd_seq
// Brief    : ALU command sequencer with MAC accumulator. Optional sticky
//            saturation flag enabled by macro ALU_SEQ_SAT_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_seq
   import alu_seq_pkg::*;
#(
   parameter int MULT_CYC = 2,
   parameter bit MAC_SAT  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic [1:0]  cmd_op,
   input  logic        cmd_sat,
   input  logic [1:0]  cmd_scale,
   input  logic        cmd_clr,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic [15:0] dst,
   output logic [15:0] Accum,
   output logic [15:0] Pcomp,
   output logic [2:0]  src1sel,
   output logic [2:0]  src0sel,
   output logic        multiply,
   output logic        saturate,
   output logic        mult2,
   output logic        mult4,
   output logic        sub,
   output logic [15:0] res,
   output logic        res_vld
`ifdef ALU_SEQ_SAT_FLAG_EN
   ,
   output logic        sat_flg
`endif
);

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic        sat_q, sat_d;
   logic [1:0]  scale_q, scale_d;
   logic [15:0] accum_q, accum_d;
   logic [15:0] pcomp_q, pcomp_d;
   logic [15:0] mac_acc_q, mac_acc_d;
   logic [15:0] res_q, res_d;
   logic        res_vld_q, res_vld_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic        multiply_q, multiply_d;
   logic        saturate_q, saturate_d;
   logic        mult2_q, mult2_d;
   logic        mult4_q, mult4_d;
   logic        sub_q, sub_d;
   logic        accept;
   logic        capture;
   logic        tmr_load;
   logic        tmr_en;
   logic        tmr_last;

   alu_mult_timer #(
      .MULT_CYC (MULT_CYC)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .en   (tmr_en),
      .last (tmr_last)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sat_d     = sat_q;
      scale_d   = scale_q;
      accum_d   = accum_q;
      pcomp_d   = pcomp_q;
      mac_acc_d = mac_acc_q;
      accept    = 1'b0;
      capture   = 1'b0;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_vld) begin
               accept   = 1'b1;
               accum_d  = cmd_a;
               pcomp_d  = cmd_b;
               op_d     = cmd_op;
               sat_d    = cmd_sat;
               scale_d  = cmd_scale;
               tmr_load = 1'b1;
               if (cmd_clr) begin
                  mac_acc_d = 16'd0;
               end
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
               capture = 1'b1;
               accum_d = dst;
               state_d = ST_DONE;
            end else begin
               tmr_en = 1'b1;
               if (tmr_last) begin
                  capture = 1'b1;
                  if (op_q == OP_MUL) begin
                     accum_d = dst;
                     state_d = ST_DONE;
                  end else begin
                     // MAC: product goes to Pcomp, running sum is re-added next cycle
                     pcomp_d = dst;
                     accum_d = mac_acc_q;
                     state_d = ST_MAC_ADD;
                  end
               end
            end
         end
         ST_MAC_ADD: begin
            capture   = 1'b1;
            accum_d   = dst;
            mac_acc_d = dst;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered, so decode them from the next state
      multiply_d = 1'b0;
      saturate_d = 1'b0;
      mult2_d    = 1'b0;
      mult4_d    = 1'b0;
      sub_d      = 1'b0;
      if (state_d == ST_EXEC) begin
         multiply_d         = (op_d == OP_MUL) || (op_d == OP_MAC);
         sub_d              = (op_d == OP_SUB);
         saturate_d         = sat_d;
         {mult4_d, mult2_d} = scale_bits(scale_d);
      end else if (state_d == ST_MAC_ADD) begin
         saturate_d = MAC_SAT;
      end
      res_vld_d = (state_d == ST_DONE);
      res_d     = res_vld_d ? accum_d : res_q;
      cmd_rdy_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_ADD;
         sat_q      <= 1'b0;
         scale_q    <= 2'd0;
         accum_q    <= 16'd0;
         pcomp_q    <= 16'd0;
         mac_acc_q  <= 16'd0;
         res_q      <= 16'd0;
         res_vld_q  <= 1'b0;
         cmd_rdy_q  <= 1'b1;
         multiply_q <= 1'b0;
         saturate_q <= 1'b0;
         mult2_q    <= 1'b0;
         mult4_q    <= 1'b0;
         sub_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         sat_q      <= sat_d;
         scale_q    <= scale_d;
         accum_q    <= accum_d;
         pcomp_q    <= pcomp_d;
         mac_acc_q  <= mac_acc_d;
         res_q      <= res_d;
         res_vld_q  <= res_vld_d;
         cmd_rdy_q  <= cmd_rdy_d;
         multiply_q <= multiply_d;
         saturate_q <= saturate_d;
         mult2_q    <= mult2_d;
         mult4_q    <= mult4_d;
         sub_q      <= sub_d;
      end
   end

`ifdef ALU_SEQ_SAT_FLAG_EN
   logic sat_flg_q, sat_flg_d;

   always_comb begin
      sat_flg_d = sat_flg_q;
      if (accept && cmd_clr) begin
         sat_flg_d = 1'b0;
      end else if (capture && saturate_q && ((dst == 16'h7FFF) || (dst == 16'h8000))) begin
         sat_flg_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flg_q <= 1'b0;
      end else begin
         sat_flg_q <= sat_flg_d;
      end
   end

   assign sat_flg = sat_flg_q;
`endif

   assign cmd_rdy  = cmd_rdy_q;
   assign Accum    = accum_q;
   assign Pcomp    = pcomp_q;
   assign src1sel  = SRC1_ACCUM;
   assign src0sel  = SRC0_PCOMP;
   assign multiply = multiply_q;
   assign saturate = saturate_q;
   assign mult2    = mult2_q;
   assign mult4    = mult4_q;
   assign sub      = sub_q;
   assign res      = res_q;
   assign res_vld  = res_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
// ============================================================================
// Module   : tb_alu_cmd_seq
// Brief    : Directed bench for alu_cmd_seq with a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [1:0]  cmd_op;
   logic        cmd_sat;
   logic [1:0]  cmd_scale;
   logic        cmd_clr;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] dst;
   logic [15:0] Accum;
   logic [15:0] Pcomp;
   logic [2:0]  src1sel;
   logic [2:0]  src0sel;
   logic        multiply;
   logic        saturate;
   logic        mult2;
   logic        mult4;
   logic        sub;
   logic [15:0] res;
   logic        res_vld;
`ifdef ALU_SEQ_SAT_FLAG_EN
   logic        sat_flg;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_cmd_seq #(
      .MULT_CYC (2),
      .MAC_SAT  (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_vld   (cmd_vld),
      .cmd_rdy   (cmd_rdy),
      .cmd_op    (cmd_op),
      .cmd_sat   (cmd_sat),
      .cmd_scale (cmd_scale),
      .cmd_clr   (cmd_clr),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .dst       (dst),
      .Accum     (Accum),
      .Pcomp     (Pcomp),
      .src1sel   (src1sel),
      .src0sel   (src0sel),
      .multiply  (multiply),
      .saturate  (saturate),
      .mult2     (mult2),
      .mult4     (mult4),
      .sub       (sub),
      .res       (res),
      .res_vld   (res_vld)
`ifdef ALU_SEQ_SAT_FLAG_EN
      ,
      .sat_flg   (sat_flg)
`endif
   );

   // Behavioural ALU: saturating add/sub with scaled src0, multiply = low product bits
   logic signed [17:0] alu_a;
   logic signed [17:0] alu_b;
   logic signed [17:0] alu_s;
   logic signed [31:0] alu_p;

   always_comb begin
      alu_a = {{2{Accum[15]}}, Accum};
      alu_b = {{2{Pcomp[15]}}, Pcomp};
      if (mult4) begin
         alu_b = alu_b <<< 2;
      end else if (mult2) begin
         alu_b = alu_b <<< 1;
      end
      alu_s = sub ? (alu_a - alu_b) : (alu_a + alu_b);
      alu_p = $signed(Accum) * $signed(Pcomp);
      if (multiply) begin
         dst = alu_p[15:0];
      end else if (saturate && (alu_s > 18'sd32767)) begin
         dst = 16'h7FFF;
      end else if (saturate && (alu_s < -18'sd32768)) begin
         dst = 16'h8000;
      end else begin
         dst = alu_s[15:0];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one command for exactly the accept edge; returns in cycle N+1
   task automatic issue(input logic [1:0] op, input logic sat, input logic [1:0] scale,
                        input logic clr, input logic [15:0] a, input logic [15:0] b);
      cmd_op    = op;
      cmd_sat   = sat;
      cmd_scale = scale;
      cmd_clr   = clr;
      cmd_a     = a;
      cmd_b     = b;
      cmd_vld   = 1'b1;
      step();
      cmd_vld   = 1'b0;
   endtask

   logic [15:0] exp_q [4];
   logic [1:0]  ops_q [4];
   logic [15:0] a_q   [4];
   logic [15:0] b_q   [4];
   int          idx;
   int          nres;
   logic        will_accept;

   initial begin
      rst = 1'b1; cmd_vld = 1'b0; cmd_op = 2'd0; cmd_sat = 1'b0; cmd_scale = 2'd0;
      cmd_clr = 1'b0; cmd_a = 16'd0; cmd_b = 16'd0;
      step();
      step();
      chk("rst_accum", Accum, 16'h0000);
      chk("rst_pcomp", Pcomp, 16'h0000);
      chk("rst_res", res, 16'h0000);
      chk("rst_res_vld", {15'd0, res_vld}, 16'd0);
      chk("rst_ctrl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'd0);
      rst = 1'b0;
      step();
      chk("rdy_after_rst", {15'd0, cmd_rdy}, 16'd1);
      chk("src1sel", {13'd0, src1sel}, 16'h0000);
      chk("src0sel", {13'd0, src0sel}, 16'h0003);

      // ADD 1 + 2, saturate requested
      issue(2'd0, 1'b1, 2'd0, 1'b0, 16'h0001, 16'h0002);
      chk("add_exec_accum", Accum, 16'h0001);
      chk("add_exec_pcomp", Pcomp, 16'h0002);
      chk("add_exec_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("add_exec_ctl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'b01000);
      chk("add_exec_vld", {15'd0, res_vld}, 16'd0);
      step();
      chk("add_done_vld", {15'd0, res_vld}, 16'd1);
      chk("add_done_res", res, 16'h0003);
      chk("add_done_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("add_done_ctl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'd0);
      step();
      chk("add_idle_vld", {15'd0, res_vld}, 16'd0);
      chk("add_idle_rdy", {15'd0, cmd_rdy}, 16'd1);
      chk("add_res_hold", res, 16'h0003);

      // SUB 0x8000 - 1 saturates to 0x8000
      issue(2'd1, 1'b1, 2'd0, 1'b0, 16'h8000, 16'h0001);
      chk("sub_exec_ctl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'b01001);
      step();
      chk("sub_done_vld", {15'd0, res_vld}, 16'd1);
      chk("sub_done_res", res, 16'h8000);
`ifdef ALU_SEQ_SAT_FLAG_EN
      chk("sub_sat_flg", {15'd0, sat_flg}, 16'd1);
`endif
      step();

      // ADD with both scale bits: mult4 only, 1 + 3*4 = 13
      issue(2'd0, 1'b0, 2'b11, 1'b0, 16'h0001, 16'h0003);
      chk("scale11_ctl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'b00010);
      step();
      chk("scale11_res", res, 16'h000D);
      step();
      issue(2'd0, 1'b0, 2'b01, 1'b0, 16'h0001, 16'h0003);
      chk("scale01_ctl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'b00100);
      step();
      chk("scale01_res", res, 16'h0007);
      step();

      // MUL 5 * 1, multiply held exactly two cycles
      issue(2'd2, 1'b0, 2'd0, 1'b0, 16'h0005, 16'h0001);
      chk("mul_c1_mult", {15'd0, multiply}, 16'd1);
      step();
      chk("mul_c2_mult", {15'd0, multiply}, 16'd1);
      chk("mul_c2_vld", {15'd0, res_vld}, 16'd0);
      step();
      chk("mul_c3_mult", {15'd0, multiply}, 16'd0);
      chk("mul_c3_vld", {15'd0, res_vld}, 16'd1);
      chk("mul_c3_res", res, 16'h0005);
      step();
      chk("mul_idle_rdy", {15'd0, cmd_rdy}, 16'd1);

      // MAC chain: clr, 3*4 -> 12; then 2*5 + 12 -> 22
      issue(2'd3, 1'b0, 2'd0, 1'b1, 16'h0003, 16'h0004);
      step();
      step();
      chk("mac1_add_ctl", {11'd0, multiply, saturate, mult2, mult4, sub}, 16'b01000);
      chk("mac1_add_accum", Accum, 16'h0000);
      chk("mac1_add_pcomp", Pcomp, 16'h000C);
      chk("mac1_add_vld", {15'd0, res_vld}, 16'd0);
      step();
      chk("mac1_vld", {15'd0, res_vld}, 16'd1);
      chk("mac1_res", res, 16'h000C);
`ifdef ALU_SEQ_SAT_FLAG_EN
      chk("mac1_sat_flg_clr", {15'd0, sat_flg}, 16'd0);
`endif
      step();
      issue(2'd3, 1'b0, 2'd0, 1'b0, 16'h0002, 16'h0005);
      step();
      step();
      step();
      chk("mac2_vld", {15'd0, res_vld}, 16'd1);
      chk("mac2_res", res, 16'h0016);
      step();

      // Async reset in cycle 2 of a MUL
      issue(2'd2, 1'b0, 2'd0, 1'b0, 16'h0009, 16'h0009);
      step();
      rst = 1'b1;
      #1;
      chk("arst_mult", {15'd0, multiply}, 16'd0);
      chk("arst_accum", Accum, 16'h0000);
      chk("arst_res", res, 16'h0000);
      step();
      chk("arst_vld", {15'd0, res_vld}, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_no_vld", {15'd0, res_vld}, 16'd0);
      end
      chk("post_rst_rdy", {15'd0, cmd_rdy}, 16'd1);
      issue(2'd0, 1'b0, 2'd0, 1'b0, 16'h0007, 16'h0008);
      step();
      chk("post_rst_add_vld", {15'd0, res_vld}, 16'd1);
      chk("post_rst_add_res", res, 16'h000F);
      step();

      // cmd_vld held high with alternating ADD/MUL
      ops_q[0] = 2'd0; a_q[0] = 16'h000A; b_q[0] = 16'h0014; exp_q[0] = 16'h001E;
      ops_q[1] = 2'd2; a_q[1] = 16'h0003; b_q[1] = 16'h0007; exp_q[1] = 16'h0015;
      ops_q[2] = 2'd0; a_q[2] = 16'h0100; b_q[2] = 16'h0001; exp_q[2] = 16'h0101;
      ops_q[3] = 2'd2; a_q[3] = 16'hFFFE; b_q[3] = 16'h0003; exp_q[3] = 16'hFFFA;
      idx = 0;
      nres = 0;
      cmd_sat = 1'b0; cmd_scale = 2'd0; cmd_clr = 1'b0;
      cmd_op = ops_q[0]; cmd_a = a_q[0]; cmd_b = b_q[0];
      cmd_vld = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         will_accept = cmd_vld && cmd_rdy;
         step();
         if (will_accept) begin
            idx++;
            if (idx < 4) begin
               cmd_op = ops_q[idx]; cmd_a = a_q[idx]; cmd_b = b_q[idx];
            end else begin
               cmd_vld = 1'b0;
            end
         end
         if (res_vld) begin
            if (nres < 4) begin
               chk("stream_res", res, exp_q[nres]);
            end else begin
               chk("stream_extra_res", {15'd0, res_vld}, 16'd0);
            end
            nres++;
         end
      end
      chk("stream_accepted", 16'(idx), 16'd4);
      chk("stream_results", 16'(nres), 16'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
